// File: rtl/vend_transaction_controller.sv
// Vending transaction sequencer: collects coins into a credit register,
// validates a product selection against stock and price, hands the vend
// to the dispenser with a req/ack handshake and pays change greedily.
module vend_transaction_controller #(
  parameter logic [15:0] MAX_CREDIT     = 16'd20000,
  parameter int          TIMEOUT_CYCLES = 1000,
  parameter int          TO_W           = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        coin_valid,
  input  logic [1:0]  coin_type,
  input  logic        select_valid,
  input  logic [2:0]  select_id,
  input  logic        cancel,
  input  logic [15:0] prod_price,
  input  logic [4:0]  prod_stock,
  input  logic        vend_ack,
  input  logic        chg_ready,
  output logic [2:0]  prod_id,
  output logic        vend_req,
  output logic        chg_valid,
  output logic [1:0]  chg_type,
  output logic [15:0] credit,
  output logic [2:0]  state,
  output logic        coin_reject,
  output logic [1:0]  err_code,
  output logic        sold
);

  localparam logic [2:0] S_IDLE    = 3'd0;
  localparam logic [2:0] S_COLLECT = 3'd1;
  localparam logic [2:0] S_CHECK   = 3'd2;
  localparam logic [2:0] S_VEND    = 3'd3;
  localparam logic [2:0] S_CHANGE  = 3'd4;

  localparam logic [15:0] MIN_COIN = 16'd500;

  logic [2:0]      state_reg, state_next;
  logic [15:0]     credit_reg, credit_next;
  logic [2:0]      prod_id_reg, prod_id_next;
  logic [1:0]      err_reg, err_next;
  logic            vend_req_reg, vend_req_next;
  logic            coin_reject_reg, coin_reject_next;
  logic            sold_reg, sold_next;
  logic [TO_W-1:0] to_cnt_reg, to_cnt_next;

  logic [15:0] coin_val;
  logic [16:0] credit_sum;
  logic        coin_fits;
  logic [1:0]  greedy_type;
  logic        chg_active;
  logic        to_expired;

  function automatic logic [15:0] coin_value(input logic [1:0] code);
    case (code)
      2'b00:   coin_value = 16'd500;
      2'b01:   coin_value = 16'd1000;
      2'b10:   coin_value = 16'd2000;
      default: coin_value = 16'd5000;
    endcase
  endfunction

  // Shared datapath terms: coin acceptance, greedy change coin, timeout hit.
  always_comb begin
    coin_val    = coin_value(coin_type);
    credit_sum  = {1'b0, credit_reg} + {1'b0, coin_val};
    coin_fits   = (credit_sum <= {1'b0, MAX_CREDIT});
    if (credit_reg >= 16'd5000)      greedy_type = 2'b11;
    else if (credit_reg >= 16'd2000) greedy_type = 2'b10;
    else if (credit_reg >= 16'd1000) greedy_type = 2'b01;
    else                             greedy_type = 2'b00;
    chg_active  = (state_reg == S_CHANGE) && (credit_reg >= MIN_COIN);
    to_expired  = (to_cnt_reg == TO_W'(TIMEOUT_CYCLES - 1));
  end

  // Next-state and datapath update for the transaction FSM.
  always_comb begin
    state_next       = state_reg;
    credit_next      = credit_reg;
    prod_id_next     = prod_id_reg;
    err_next         = err_reg;
    vend_req_next    = vend_req_reg;
    coin_reject_next = 1'b0;
    sold_next        = 1'b0;
    to_cnt_next      = '0;
    case (state_reg)
      S_IDLE: begin
        if (coin_valid) begin
          if (coin_fits) begin
            credit_next = credit_sum[15:0];
            err_next    = 2'b00;
            state_next  = S_COLLECT;
          end else begin
            coin_reject_next = 1'b1;
          end
        end
      end
      S_COLLECT: begin
        if (cancel) begin
          // A refund request wins; any coin alongside it is bounced.
          coin_reject_next = coin_valid;
          state_next       = S_CHANGE;
        end else begin
          if (coin_valid) begin
            if (coin_fits) begin
              credit_next = credit_sum[15:0];
              err_next    = 2'b00;
            end else begin
              coin_reject_next = 1'b1;
            end
          end
          if (select_valid) begin
            prod_id_next = select_id;
            state_next   = S_CHECK;
          end else if (coin_valid && coin_fits) begin
            to_cnt_next = '0;
          end else if (to_expired) begin
            err_next   = 2'b11;
            state_next = S_CHANGE;
          end else begin
            to_cnt_next = to_cnt_reg + TO_W'(1);
          end
        end
      end
      S_CHECK: begin
        coin_reject_next = coin_valid;
        if (prod_stock == 5'd0) begin
          err_next   = 2'b01;
          state_next = S_COLLECT;
        end else if (credit_reg < prod_price) begin
          err_next   = 2'b10;
          state_next = S_COLLECT;
        end else begin
          credit_next   = credit_reg - prod_price;
          err_next      = 2'b00;
          vend_req_next = 1'b1;
          state_next    = S_VEND;
        end
      end
      S_VEND: begin
        coin_reject_next = coin_valid;
        if (vend_ack) begin
          vend_req_next = 1'b0;
          sold_next     = 1'b1;
          state_next    = (credit_reg >= MIN_COIN) ? S_CHANGE : S_IDLE;
        end
      end
      S_CHANGE: begin
        coin_reject_next = coin_valid;
        if (credit_reg >= MIN_COIN) begin
          if (chg_ready) credit_next = credit_reg - coin_value(greedy_type);
        end else begin
          // Residue below the smallest coin cannot be paid out.
          credit_next = '0;
          state_next  = S_IDLE;
        end
      end
      default: begin
        coin_reject_next = coin_valid;
        vend_req_next    = 1'b0;
        state_next       = S_IDLE;
      end
    endcase
  end

  // State registers with asynchronous reset.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_reg       <= S_IDLE;
      credit_reg      <= '0;
      prod_id_reg     <= '0;
      err_reg         <= 2'b00;
      vend_req_reg    <= 1'b0;
      coin_reject_reg <= 1'b0;
      sold_reg        <= 1'b0;
      to_cnt_reg      <= '0;
    end else begin
      state_reg       <= state_next;
      credit_reg      <= credit_next;
      prod_id_reg     <= prod_id_next;
      err_reg         <= err_next;
      vend_req_reg    <= vend_req_next;
      coin_reject_reg <= coin_reject_next;
      sold_reg        <= sold_next;
      to_cnt_reg      <= to_cnt_next;
    end
  end

  // Change offer follows the registered credit, so chg_type tracks each payout.
  always_comb begin
    chg_valid = chg_active;
    chg_type  = chg_active ? greedy_type : 2'b00;
  end

  assign state       = state_reg;
  assign credit      = credit_reg;
  assign prod_id     = prod_id_reg;
  assign err_code    = err_reg;
  assign vend_req    = vend_req_reg;
  assign coin_reject = coin_reject_reg;
  assign sold        = sold_reg;

endmodule

// File: tb/tb_vend_transaction_controller.sv
// Bench for vend_transaction_controller: directed scenarios followed by
// randomized transactions, all checked against a transaction-level model.
module tb_vend_transaction_controller;

  localparam int IDLE = 0, COLLECT = 1, CHECK = 2, VEND = 3, CHANGE = 4;
  localparam int MAXC = 20000;
  localparam int TOUT = 1000;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        coin_valid = 1'b0;
  logic [1:0]  coin_type = 2'b00;
  logic        select_valid = 1'b0;
  logic [2:0]  select_id = 3'd0;
  logic        cancel = 1'b0;
  logic [15:0] prod_price;
  logic [4:0]  prod_stock;
  logic        vend_ack = 1'b0;
  logic        chg_ready = 1'b0;
  logic [2:0]  prod_id;
  logic        vend_req, chg_valid, coin_reject, sold;
  logic [1:0]  chg_type, err_code;
  logic [15:0] credit;
  logic [2:0]  state;

  logic [15:0] price_tbl [8];
  logic [4:0]  stock_tbl [8];
  assign prod_price = price_tbl[prod_id];
  assign prod_stock = stock_tbl[prod_id];

  vend_transaction_controller dut (
    .clk(clk), .reset(reset), .coin_valid(coin_valid), .coin_type(coin_type),
    .select_valid(select_valid), .select_id(select_id), .cancel(cancel),
    .prod_price(prod_price), .prod_stock(prod_stock), .vend_ack(vend_ack),
    .chg_ready(chg_ready), .prod_id(prod_id), .vend_req(vend_req),
    .chg_valid(chg_valid), .chg_type(chg_type), .credit(credit), .state(state),
    .coin_reject(coin_reject), .err_code(err_code), .sold(sold)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;
  int m_state, m_credit, m_err;
  int vals [4] = '{500, 1000, 2000, 5000};

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Largest coin code whose value does not exceed c.
  function automatic int greedy_code(input int c);
    for (int k = 3; k >= 0; k--) if (c >= vals[k]) return k;
    return 0;
  endfunction

  task automatic model_reset();
    m_state = IDLE; m_credit = 0; m_err = 0;
  endtask

  task automatic coin(input int t);
    bit acc;
    acc = (m_state == IDLE || m_state == COLLECT) && (m_credit + vals[t] <= MAXC);
    coin_valid = 1'b1; coin_type = 2'(t);
    tick();
    coin_valid = 1'b0;
    if (acc) begin
      m_credit += vals[t]; m_err = 0;
      if (m_state == IDLE) m_state = COLLECT;
    end
    $display("coin %0d: accepted=%0d credit=%0d state=%0d", vals[t], acc, credit, state);
    check("coin_reject", coin_reject, !acc);
    check("coin_credit", credit, m_credit);
    check("coin_state", state, m_state);
    check("coin_err", err_code, m_err);
  endtask

  task automatic select(input int id);
    select_valid = 1'b1; select_id = 3'(id);
    tick();
    select_valid = 1'b0;
    check("sel_state_check", state, CHECK);
    check("sel_prod_id", prod_id, id);
    tick();
    if (stock_tbl[id] == 0) begin
      m_err = 1; m_state = COLLECT;
    end else if (m_credit < int'(price_tbl[id])) begin
      m_err = 2; m_state = COLLECT;
    end else begin
      m_credit -= int'(price_tbl[id]); m_err = 0; m_state = VEND;
    end
    $display("select %0d price=%0d stock=%0d: state=%0d err=%0d credit=%0d",
             id, price_tbl[id], stock_tbl[id], state, err_code, credit);
    check("sel_state", state, m_state);
    check("sel_err", err_code, m_err);
    check("sel_credit", credit, m_credit);
    check("sel_vend_req", vend_req, m_state == VEND);
  endtask

  task automatic vend_done(input int delay);
    for (int i = 0; i < delay; i++) begin
      check("vend_req_hold", vend_req, 1);
      tick();
    end
    vend_ack = 1'b1;
    tick();
    vend_ack = 1'b0;
    m_state = (m_credit >= 500) ? CHANGE : IDLE;
    $display("vend ack: sold=%0d vend_req=%0d state=%0d", sold, vend_req, state);
    check("sold_pulse", sold, 1);
    check("vend_req_drop", vend_req, 0);
    check("vend_next_state", state, m_state);
    tick();
    check("sold_one_cycle", sold, 0);
    check("post_vend_chg_valid", chg_valid, m_state == CHANGE && m_credit >= 500);
  endtask

  task automatic cancel_req(input bit with_coin, input int t);
    cancel = 1'b1; coin_valid = with_coin; coin_type = 2'(t);
    tick();
    cancel = 1'b0; coin_valid = 1'b0;
    m_state = CHANGE;
    $display("cancel (coin=%0d): state=%0d credit=%0d", with_coin, state, credit);
    check("cancel_state", state, CHANGE);
    check("cancel_coin_reject", coin_reject, with_coin);
    check("cancel_credit", credit, m_credit);
  endtask

  // Drain change with chg_ready asserted pct% of cycles.
  task automatic change(input int pct);
    int budget;
    bit rdy, exp_valid;
    int code;
    budget = 200;
    check("change_entry", state, CHANGE);
    while (state == 3'(CHANGE) && budget > 0) begin
      exp_valid = (m_credit >= 500);
      code = greedy_code(m_credit);
      check("chg_valid", chg_valid, exp_valid);
      if (exp_valid) check("chg_type", chg_type, code);
      rdy = ($urandom_range(0, 99) < pct);
      chg_ready = rdy;
      tick();
      if (exp_valid && rdy) begin
        m_credit -= vals[code];
        $display("change coin %0d paid, credit=%0d", vals[code], credit);
      end else if (!exp_valid) begin
        m_credit = 0;
      end
      check("chg_credit", credit, m_credit);
      budget--;
    end
    chg_ready = 1'b0;
    check("change_budget", budget > 0, 1);
    m_state = IDLE;
    check("change_done_state", state, IDLE);
    check("change_done_credit", credit, 0);
    check("change_done_err", err_code, m_err);
  endtask

  initial begin
    int ncoin, id, r;
    price_tbl = '{16'd1000, 16'd2500, 16'd1500, 16'd3000, 16'd2000, 16'd500, 16'd4000, 16'd8000};
    stock_tbl = '{5'd3, 5'd7, 5'd10, 5'd2, 5'd0, 5'd1, 5'd4, 5'd9};
    model_reset();
    tick(); tick();
    check("rst_state", state, IDLE);
    check("rst_credit", credit, 0);
    check("rst_prod_id", prod_id, 0);
    check("rst_err", err_code, 0);
    check("rst_outputs", {vend_req, chg_valid, chg_type, coin_reject, sold}, 0);
    reset = 1'b0;
    tick();

    // Exact payment, no change.
    coin(1); coin(0); select(2); vend_done(2);
    check("exact_no_chg", chg_valid, 0);

    // Vend with 4500 change: 2000, 2000, 500.
    coin(3); coin(2); select(1); vend_done(0); change(100);

    // Insufficient funds, then a coin clears the error.
    coin(1); select(3); coin(3);
    cancel_req(1'b1, 0); change(100);

    // Sold out, then cancel refunds 1000 as a single coin.
    coin(1); select(4); cancel_req(1'b0, 0); change(100);

    // Credit cap and coins during VEND.
    coin(3); coin(3); coin(3); coin(2); coin(1); coin(3);
    select(1); coin(0); vend_done(1); change(60);

    // Timeout refund on the TIMEOUT_CYCLES-th idle cycle.
    coin(0);
    repeat (TOUT - 1) tick();
    check("timeout_not_yet", state, COLLECT);
    tick();
    m_err = 3; m_state = CHANGE;
    $display("timeout: state=%0d err=%0d", state, err_code);
    check("timeout_state", state, CHANGE);
    check("timeout_err", err_code, 3);
    change(100);

    // Asynchronous reset in the middle of VEND.
    coin(3); select(0);
    #2 reset = 1'b1;
    #1;
    $display("async reset in VEND: vend_req=%0d credit=%0d state=%0d", vend_req, credit, state);
    check("areset_vend_req", vend_req, 0);
    check("areset_credit", credit, 0);
    check("areset_state", state, IDLE);
    tick();
    reset = 1'b0;
    model_reset();

    // Randomized transactions.
    for (int n = 0; n < 25; n++) begin
      for (int k = 0; k < 8; k++) begin
        price_tbl[k] = 16'(500 * $urandom_range(1, 16));
        stock_tbl[k] = 5'($urandom_range(0, 3));
      end
      ncoin = $urandom_range(1, 6);
      for (int c = 0; c < ncoin; c++) begin
        coin($urandom_range(0, 3));
        repeat ($urandom_range(0, 2)) tick();
      end
      r = $urandom_range(0, 9);
      if (r == 0) begin
        cancel_req(1'($urandom_range(0, 1)), $urandom_range(0, 3));
        change($urandom_range(30, 100));
      end else begin
        id = $urandom_range(0, 7);
        select(id);
        if (m_state == VEND) begin
          if (r < 4) coin($urandom_range(0, 3));
          vend_done($urandom_range(0, 3));
          if (m_state == CHANGE) change($urandom_range(30, 100));
        end else begin
          cancel_req(1'b0, 0);
          change($urandom_range(30, 100));
        end
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
